// File: rtl/lcd_cmd_sched.sv
// lcd_cmd_sched: queues host commands for an LCD controller and issues
// them one at a time. Write commands (code 0) are held until the controller
// answers with a done pulse. If done does not arrive within TIMEOUT cycles,
// the scheduler locks into a sticky ERROR state, and only reset clears it.
//
// Ports
//   clk          rising-edge clock
//   reset        synchronous active-low reset
//   host_cmd     command code to enqueue (0 write, 1-4 shifts, 5 avg, 6/7 mirror)
//   host_valid   enqueue request; a push happens on host_valid && host_ready
//   host_ready   FIFO has room and the scheduler is not in ERROR
//   cmd          last issued command (registered, held between issues)
//   cmd_valid    one-cycle issue strobe (registered)
//   busy         controller busy; blocks issue while in IDLE
//   done         controller write-back complete pulse
//   fifo_count   number of queued entries, 0..DEPTH
//   sched_idle   IDLE and queue empty
//   timeout      sticky error flag
//   wr_done_cnt  completed write count, saturates at 255
module lcd_cmd_sched #(
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] host_cmd,
    input  logic       host_valid,
    output logic       host_ready,
    output logic [2:0] cmd,
    output logic       cmd_valid,
    input  logic       busy,
    input  logic       done,
    output logic [3:0] fifo_count,
    output logic       sched_idle,
    output logic       timeout,
    output logic [7:0] wr_done_cnt
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int              TW       = $clog2(TIMEOUT + 1);
    localparam logic [3:0]      DEPTH_C  = 4'(DEPTH);
    localparam logic [AW-1:0]   PTR_LAST = AW'(DEPTH - 1);
    localparam logic [TW-1:0]   TO_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        HOLD,
        WAIT_DONE,
        ERROR
    } state_t;

    state_t        state, state_n;
    logic [2:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [TW-1:0] to_cnt;
    logic          push, pop, wr_ok;

    // Readiness depends on registered state only. A pop in the same cycle
    // does not open a slot for a push into a full FIFO.
    assign host_ready = (fifo_count < DEPTH_C) && (state != ERROR);
    assign push       = host_valid && host_ready;
    assign sched_idle = (state == IDLE) && (fifo_count == 4'd0);

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        wr_ok   = 1'b0;
        case (state)
            IDLE: begin
                // fifo_count is registered. An entry pushed at this edge
                // cannot be popped until the next edge (no fall-through).
                if (fifo_count != 4'd0 && !busy) begin
                    pop     = 1'b1;
                    state_n = ISSUE;
                end
            end
            ISSUE:     state_n = HOLD;
            // busy is ignored for one cycle while the controller raises it.
            HOLD:      state_n = (cmd == 3'd0) ? WAIT_DONE : IDLE;
            WAIT_DONE: begin
                // done takes priority over timeout expiry in the same cycle.
                if (done) begin
                    wr_ok   = 1'b1;
                    state_n = IDLE;
                end else if (to_cnt == TO_LAST) begin
                    state_n = ERROR;
                end
            end
            ERROR:     state_n = ERROR;
            default:   state_n = IDLE;
        endcase
    end

    // The storage array needs no reset. The pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= host_cmd;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= 4'd0;
            cmd         <= 3'd0;
            cmd_valid   <= 1'b0;
            timeout     <= 1'b0;
            wr_done_cnt <= 8'd0;
            to_cnt      <= '0;
        end else begin
            state     <= state_n;
            cmd_valid <= pop;

            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;

            if (pop) begin
                cmd    <= mem[rd_ptr];
                rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
            end

            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 4'd1;
                2'b01:   fifo_count <= fifo_count - 4'd1;
                default: fifo_count <= fifo_count;
            endcase

            // Counts cycles spent in WAIT_DONE. It restarts on every entry.
            to_cnt <= (state == WAIT_DONE) ? to_cnt + 1'b1 : '0;

            if (wr_ok && wr_done_cnt != 8'hFF) wr_done_cnt <= wr_done_cnt + 8'd1;

            if (state_n == ERROR) timeout <= 1'b1;
        end
    end

endmodule

// File: doc/lcd_cmd_sched.md
LCD_CMD_SCHED -- requirements
Module: lcd_cmd_sched

Interface
REQ-001 Parameter DEPTH, default 8, command FIFO depth in entries (power of 2).
REQ-002 Parameter TIMEOUT, default 1023, maximum cycles spent waiting for done after a write command.
REQ-003 clk  input  1  single rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk edge.
REQ-005 host_cmd  input  3  command code to enqueue: 0 write, 1-4 shift up/down/left/right, 5 average, 6 mirror X, 7 mirror Y.
REQ-006 host_valid  input  1  host enqueue request.
REQ-007 host_ready  output  1  FIFO can accept; push occurs iff host_valid && host_ready at a rising edge.
REQ-008 cmd  output  3  command to the LCD controller, registered.
REQ-009 cmd_valid  output  1  one-cycle issue strobe to the LCD controller, registered.
REQ-010 busy  input  1  LCD controller busy.
REQ-011 done  input  1  LCD controller write-back complete pulse.
REQ-012 fifo_count  output  4  occupied FIFO entries, 0..DEPTH.
REQ-013 sched_idle  output  1  high when state IDLE and fifo_count==0.
REQ-014 timeout  output  1  sticky error flag.
REQ-015 wr_done_cnt  output  8  number of completed write commands, saturating.

Function
REQ-016 The FIFO SHALL be first-in first-out, circular, with DEPTH entries; read/write pointers wrap from DEPTH-1 to 0.
REQ-017 host_ready SHALL equal (fifo_count<DEPTH) && (state!=ERROR), derived from registered state only; a simultaneous pop does not make a full FIFO ready in that cycle.
REQ-018 A simultaneous push and pop SHALL leave fifo_count unchanged; a push into an empty FIFO is not eligible for issue until the following edge (no fall-through).
REQ-019 FSM states SHALL be IDLE, ISSUE, HOLD, WAIT_DONE, ERROR.
REQ-020 IDLE: when fifo_count>0 and busy==0, pop head, load cmd, assert cmd_valid, go to ISSUE; otherwise stay, with cmd_valid=0.
REQ-021 ISSUE: cmd_valid SHALL deassert at the next edge (exactly one cycle high); go to HOLD.
REQ-022 HOLD: one cycle in which busy is ignored (covers controller busy latency); then go to WAIT_DONE if the issued cmd==0, else IDLE.
REQ-023 WAIT_DONE: on done==1 increment wr_done_cnt (saturate at 255) and go to IDLE; the timeout counter increments each cycle and, on reaching TIMEOUT without done, the FSM SHALL go to ERROR.
REQ-024 done asserted outside WAIT_DONE SHALL be ignored; done and timeout expiry in the same cycle SHALL count as done.
REQ-025 ERROR: timeout=1, cmd_valid=0, host_ready=0, no pops; exit only by reset.
REQ-026 cmd SHALL hold its last issued value between issues.
REQ-027 Latency: push at edge k into an empty FIFO with state IDLE and busy=0 SHALL produce cmd_valid=1 after edge k+1.
REQ-028 host_valid while host_ready==0 SHALL be dropped with no state change.

Reset
REQ-029 While reset==0 at an edge: state IDLE, FIFO pointers and fifo_count=0, cmd=0, cmd_valid=0, timeout=0, wr_done_cnt=0, timeout counter=0.
REQ-030 Reset asserted mid-operation (any state, including WAIT_DONE or ERROR) SHALL discard all queued commands and take effect at that edge; host_ready=1 and sched_idle=1 from the first cycle after reset deasserts.

Verification
REQ-031 Reset, push 3 (shift down) with busy=0 -> cmd=3, cmd_valid high exactly one cycle, 2 edges after push; fifo_count back to 0; wr_done_cnt=0.
REQ-032 Push 8 commands with busy=1 held -> fifo_count=8, host_ready=0, 9th push dropped; release busy -> 8 commands issued in push order, each cmd_valid separated by >=3 cycles.
REQ-033 Push 0 (write), controller pulses done 70 cycles later -> FSM stays in WAIT_DONE with no further issues until done; wr_done_cnt=1; next queued command issues afterwards.
REQ-034 Push 0, done never arrives -> after 1023 cycles in WAIT_DONE timeout=1, host_ready=0, queued commands never issued; reset low -> timeout=0, fifo_count=0.
REQ-035 Full FIFO with a pop and a host_valid in the same cycle -> push dropped, fifo_count=7; pointer wrap after 12 push/pop pairs preserves order.
REQ-036 Issue 300 write commands, each answered with done -> wr_done_cnt saturates at 255.
